// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared packet codes and audio constants for the HDMI packet scheduler
package hdmi_pkg;

  localparam int SAMPLE_WIDTH       = 32;
  localparam int SAMPLES_PER_PACKET = 4;
  localparam int IEC_BLOCK_LENGTH   = 192;

  typedef enum logic [7:0] {
    PKT_NULL     = 8'h00,
    PKT_ACR      = 8'h01,
    PKT_AUDIO    = 8'h02,
    PKT_AVI      = 8'h82,
    PKT_SPD      = 8'h83,
    PKT_AUDIO_IF = 8'h84
  } packetCode_e;

  typedef enum logic {
    IDLE,
    GRANT
  } schedState_e;

endpackage

// File: rtl/hdmi_packet_scheduler_audio_sample_buffer.sv
// rtl/hdmi_packet_scheduler_audio_sample_buffer.sv - 4-slot audio sample buffer with IEC 60958 frame index
module audio_sample_buffer
  import hdmi_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic                                     pushEnable,
  input  logic [SAMPLE_WIDTH-1:0]                  pushData,
  input  logic                                     clearEnable,
  output logic [2:0]                               count,
  output logic [SAMPLES_PER_PACKET-1:0]            present,
  output logic [SAMPLES_PER_PACKET-1:0]            blockStart,
  output logic [SAMPLES_PER_PACKET*SAMPLE_WIDTH-1:0] data
);

  logic [SAMPLE_WIDTH-1:0] slot [SAMPLES_PER_PACKET];
  logic [7:0]              iecIndex;
  logic [8:0]              advanced;

  assign advanced = {1'b0, iecIndex} + {6'd0, count};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count    <= 3'd0;
      iecIndex <= 8'd0;
      for (int k = 0; k < SAMPLES_PER_PACKET; k++) slot[k] <= '0;
    end else if (clearEnable) begin
      count    <= 3'd0;
      iecIndex <= (advanced >= 9'(IEC_BLOCK_LENGTH)) ? 8'(advanced - 9'(IEC_BLOCK_LENGTH))
                                                     : advanced[7:0];
    end else if (pushEnable && count < 3'(SAMPLES_PER_PACKET)) begin
      slot[count[1:0]] <= pushData;
      count            <= count + 3'd1;
    end
  end

  // Index + slot never exceeds 194, so frame 0 is either sum 0 or sum 192.
  always_comb begin
    present    = '0;
    blockStart = '0;
    data       = '0;
    for (int k = 0; k < SAMPLES_PER_PACKET; k++) begin
      if (3'(k) < count) begin
        present[k]                             = 1'b1;
        blockStart[k]                          = ({1'b0, iecIndex} + 9'(k) == 9'd0) ||
                                                 ({1'b0, iecIndex} + 9'(k) == 9'(IEC_BLOCK_LENGTH));
        data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]   = slot[k];
      end
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// rtl/hdmi_packet_scheduler.sv - picks the data-island packet for each blanking slot
module hdmi_packet_scheduler
  import hdmi_pkg::*;
(
  input  logic                                      pixelClock,
  input  logic                                      asyncResetN,
  input  logic                                      vSync,
  input  logic                                      slotRequest,
  input  logic                                      packetDone,
  input  logic [7:0]                                samplesPerRegenPacket,
  input  logic                                      sampleFifoEmpty,
  input  logic [SAMPLE_WIDTH-1:0]                   sampleFifoReadData,
  output logic                                      sampleFifoReadEnable,
  output logic                                      packetValid,
  output logic [7:0]                                packetType,
  output logic [SAMPLES_PER_PACKET-1:0]             samplePresent,
  output logic [SAMPLES_PER_PACKET-1:0]             sampleBlockStart,
  output logic [SAMPLES_PER_PACKET*SAMPLE_WIDTH-1:0] sampleData,
  output logic                                      infoframeMissed
);

  schedState_e state, nextState;
  packetCode_e grantType, nextGrantType, decidedType;
  logic [7:0]  acrCount;
  logic        aviPending, spdPending, audioIfPending;
  logic        vSyncQ, vSyncRise, anyPending;
  logic [2:0]  bufCount;
  logic        popEnable, grantDone, clearBuffer;

  // Gated by reset so a word is never popped into a buffer that is held in reset.
  assign popEnable   = asyncResetN && (state == IDLE) && !sampleFifoEmpty &&
                       (bufCount < 3'(SAMPLES_PER_PACKET));
  assign grantDone   = (state == GRANT) && packetDone;
  assign clearBuffer = grantDone && (grantType == PKT_AUDIO);
  assign vSyncRise   = vSync && !vSyncQ;
  assign anyPending  = aviPending || spdPending || audioIfPending;

  assign sampleFifoReadEnable = popEnable;
  assign packetValid          = (state == GRANT);
  assign packetType           = grantType;

  audio_sample_buffer sampleBuffer (
    .clk         (pixelClock),
    .rstN        (asyncResetN),
    .pushEnable  (popEnable),
    .pushData    (sampleFifoReadData),
    .clearEnable (clearBuffer),
    .count       (bufCount),
    .present     (samplePresent),
    .blockStart  (sampleBlockStart),
    .data        (sampleData)
  );

  always_comb begin
    decidedType = PKT_NULL;
    if (samplesPerRegenPacket != 8'd0 && acrCount >= samplesPerRegenPacket) decidedType = PKT_ACR;
    else if (bufCount == 3'(SAMPLES_PER_PACKET))                           decidedType = PKT_AUDIO;
    else if (aviPending)                                                   decidedType = PKT_AVI;
    else if (spdPending)                                                   decidedType = PKT_SPD;
    else if (audioIfPending)                                               decidedType = PKT_AUDIO_IF;
    else if (bufCount != 3'd0)                                             decidedType = PKT_AUDIO;
  end

  always_comb begin
    nextState     = state;
    nextGrantType = grantType;
    unique case (state)
      IDLE: if (slotRequest) begin
        nextState     = GRANT;
        nextGrantType = decidedType;
      end
      GRANT: if (packetDone) begin
        nextState     = IDLE;
        nextGrantType = PKT_NULL;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state     <= IDLE;
      grantType <= PKT_NULL;
    end else begin
      state     <= nextState;
      grantType <= nextGrantType;
    end
  end

  // Pops happen only in IDLE and the ACR subtract only in GRANT, so they never collide.
  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      acrCount        <= 8'd0;
      aviPending      <= 1'b0;
      spdPending      <= 1'b0;
      audioIfPending  <= 1'b0;
      vSyncQ          <= 1'b0;
      infoframeMissed <= 1'b0;
    end else begin
      vSyncQ          <= vSync;
      infoframeMissed <= vSyncRise && anyPending;
      if (popEnable && acrCount != 8'hFF) begin
        acrCount <= acrCount + 8'd1;
      end else if (grantDone && grantType == PKT_ACR) begin
        acrCount <= (acrCount > samplesPerRegenPacket) ? acrCount - samplesPerRegenPacket : 8'd0;
      end
      if (vSyncRise && !anyPending) begin
        aviPending     <= 1'b1;
        spdPending     <= 1'b1;
        audioIfPending <= 1'b1;
      end else if (grantDone) begin
        if (grantType == PKT_AVI)      aviPending     <= 1'b0;
        if (grantType == PKT_SPD)      spdPending     <= 1'b0;
        if (grantType == PKT_AUDIO_IF) audioIfPending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb/tb_hdmi_packet_scheduler.sv - self-checking bench for hdmi_packet_scheduler
module tb_hdmi_packet_scheduler;

  logic         pixelClock;
  logic         asyncResetN;
  logic         vSync;
  logic         slotRequest;
  logic         packetDone;
  logic [7:0]   samplesPerRegenPacket;
  logic         sampleFifoEmpty;
  logic [31:0]  sampleFifoReadData;
  logic         sampleFifoReadEnable;
  logic         packetValid;
  logic [7:0]   packetType;
  logic [3:0]   samplePresent;
  logic [3:0]   sampleBlockStart;
  logic [127:0] sampleData;
  logic         infoframeMissed;

  int checks = 0;
  int failures = 0;

  hdmi_packet_scheduler dut (
    .pixelClock            (pixelClock),
    .asyncResetN           (asyncResetN),
    .vSync                 (vSync),
    .slotRequest           (slotRequest),
    .packetDone            (packetDone),
    .samplesPerRegenPacket (samplesPerRegenPacket),
    .sampleFifoEmpty       (sampleFifoEmpty),
    .sampleFifoReadData    (sampleFifoReadData),
    .sampleFifoReadEnable  (sampleFifoReadEnable),
    .packetValid           (packetValid),
    .packetType            (packetType),
    .samplePresent         (samplePresent),
    .sampleBlockStart      (sampleBlockStart),
    .sampleData            (sampleData),
    .infoframeMissed       (infoframeMissed)
  );

  initial pixelClock = 1'b0;
  always #5 pixelClock = ~pixelClock;

  logic [31:0] fifoQ[$];

  // Reference model: packet buffer as a queue, frame index and ACR count as integers.
  bit          mGranted = 0;
  logic [7:0]  mType = 8'h00;
  logic [31:0] mBuf[$];
  int          mIec = 0;
  int          mAcr = 0;
  bit          mAvi = 0, mSpd = 0, mAif = 0;
  bit          mVPrev = 0;
  bit          mMissed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveFifo();
    sampleFifoEmpty    = (fifoQ.size() == 0);
    sampleFifoReadData = (fifoQ.size() == 0) ? 32'h0 : fifoQ[0];
  endtask

  task automatic modelReset();
    mGranted = 0; mType = 8'h00; mBuf.delete(); mIec = 0; mAcr = 0;
    mAvi = 0; mSpd = 0; mAif = 0; mVPrev = 0; mMissed = 0;
  endtask

  task automatic compareModel();
    logic [3:0]   ePres;
    logic [3:0]   eBs;
    logic [127:0] eData;
    logic         eRe;
    ePres = '0; eBs = '0; eData = '0;
    for (int k = 0; k < mBuf.size(); k++) begin
      ePres[k] = 1'b1;
      eBs[k]   = ((mIec + k) % 192 == 0);
      eData[k*32 +: 32] = mBuf[k];
    end
    eRe = asyncResetN && !mGranted && fifoQ.size() != 0 && mBuf.size() < 4;
    check("model_valid", packetValid, mGranted);
    check("model_type", packetType, mGranted ? mType : 8'h00);
    check("model_present", samplePresent, ePres);
    check("model_blockstart", sampleBlockStart, eBs);
    check("model_data", sampleData, eData);
    check("model_readenable", sampleFifoReadEnable, eRe);
    check("model_missed", infoframeMissed, mMissed);
  endtask

  task automatic modelStep();
    bit          rise, anyPre, pop;
    logic [7:0]  choice;
    logic [31:0] head;
    rise   = vSync && !mVPrev;
    anyPre = mAvi || mSpd || mAif;
    pop    = !mGranted && fifoQ.size() != 0 && mBuf.size() < 4;
    head   = 32'h0;
    if (pop) head = fifoQ[0];
    if (samplesPerRegenPacket != 0 && mAcr >= int'(samplesPerRegenPacket)) choice = 8'h01;
    else if (mBuf.size() == 4) choice = 8'h02;
    else if (mAvi)             choice = 8'h82;
    else if (mSpd)             choice = 8'h83;
    else if (mAif)             choice = 8'h84;
    else if (mBuf.size() > 0)  choice = 8'h02;
    else                       choice = 8'h00;
    mMissed = rise && anyPre;
    if (mGranted && packetDone) begin
      if (mType == 8'h02) begin
        mIec = (mIec + mBuf.size()) % 192;
        mBuf.delete();
      end
      if (mType == 8'h01) mAcr = (mAcr > int'(samplesPerRegenPacket)) ? mAcr - int'(samplesPerRegenPacket) : 0;
      if (mType == 8'h82) mAvi = 0;
      if (mType == 8'h83) mSpd = 0;
      if (mType == 8'h84) mAif = 0;
      mGranted = 0;
      mType = 8'h00;
    end else if (!mGranted && slotRequest) begin
      mGranted = 1;
      mType = choice;
    end
    if (pop) begin
      mBuf.push_back(head);
      if (mAcr < 255) mAcr++;
    end
    if (rise && !anyPre) begin
      mAvi = 1; mSpd = 1; mAif = 1;
    end
    mVPrev = vSync;
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic cycle();
    logic popSeen;
    driveFifo();
    @(negedge pixelClock);
    if (!asyncResetN) modelReset();
    compareModel();
    popSeen = sampleFifoReadEnable;
    if (asyncResetN) modelStep();
    @(posedge pixelClock);
    #1;
    if (popSeen && fifoQ.size() != 0) void'(fifoQ.pop_front());
    slotRequest = 1'b0;
    packetDone  = 1'b0;
    driveFifo();
  endtask

  task automatic doReset();
    asyncResetN = 1'b0;
    slotRequest = 1'b0;
    packetDone  = 1'b0;
    vSync       = 1'b0;
    fifoQ.delete();
    cycle();
    cycle();
    asyncResetN = 1'b1;
    cycle();
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) fifoQ.push_back($urandom());
  endtask

  task automatic vSyncPulse();
    vSync = 1'b1;
    cycle();
    vSync = 1'b0;
    cycle();
  endtask

  task automatic grant(output logic [7:0] typ, output logic [3:0] pres,
                       output logic [3:0] bs, output logic [127:0] dat);
    slotRequest = 1'b1;
    cycle();
    typ  = packetType;
    pres = samplePresent;
    bs   = sampleBlockStart;
    dat  = sampleData;
    check("grant_valid", packetValid, 1'b1);
    packetDone = 1'b1;
    cycle();
    check("valid_falls", packetValid, 1'b0);
  endtask

  task automatic sendPacket(input int n, output logic [7:0] typ, output logic [3:0] bs);
    logic [3:0]   pres;
    logic [127:0] dat;
    pushWords(n);
    repeat (6) cycle();
    grant(typ, pres, bs, dat);
  endtask

  typedef struct {
    int         k;
    logic [7:0] n;
    bit         vs;
    logic [7:0] expType;
    logic [3:0] expPres;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   typ;
    logic [3:0]   pres, bs;
    logic [127:0] dat, expData;
    int           missCount;

    vecs[0] = '{0, 8'd0, 1'b0, 8'h00, 4'b0000};
    vecs[1] = '{2, 8'd0, 1'b0, 8'h02, 4'b0011};
    vecs[2] = '{4, 8'd0, 1'b1, 8'h02, 4'b1111};
    vecs[3] = '{3, 8'd0, 1'b1, 8'h82, 4'b0111};
    vecs[4] = '{3, 8'd3, 1'b1, 8'h01, 4'b0111};
    vecs[5] = '{3, 8'd4, 1'b1, 8'h82, 4'b0111};
    vecs[6] = '{4, 8'd4, 1'b0, 8'h01, 4'b1111};
    vecs[7] = '{1, 8'd2, 1'b0, 8'h02, 4'b0001};
    vecs[8] = '{0, 8'd0, 1'b1, 8'h82, 4'b0000};

    asyncResetN = 1'b0; vSync = 1'b0; slotRequest = 1'b0; packetDone = 1'b0;
    samplesPerRegenPacket = 8'd0;
    driveFifo();
    @(posedge pixelClock);
    #1;
    doReset();

    check("reset_valid", packetValid, 1'b0);
    check("reset_type", packetType, 8'h00);
    check("reset_present", samplePresent, 4'b0000);
    check("reset_blockstart", sampleBlockStart, 4'b0000);
    check("reset_data", sampleData, 128'h0);
    check("reset_readenable", sampleFifoReadEnable, 1'b0);
    check("reset_missed", infoframeMissed, 1'b0);

    for (int i = 0; i < 9; i++) begin
      doReset();
      samplesPerRegenPacket = vecs[i].n;
      pushWords(vecs[i].k);
      repeat (6) cycle();
      if (vecs[i].vs) vSyncPulse();
      grant(typ, pres, bs, dat);
      check($sformatf("vec%0d_type", i), typ, vecs[i].expType);
      check($sformatf("vec%0d_present", i), pres, vecs[i].expPres);
    end

    // Six words, one slot: four popped, the rest after the packet.
    doReset();
    samplesPerRegenPacket = 8'd0;
    pushWords(6);
    for (int k = 0; k < 4; k++) expData[k*32 +: 32] = fifoQ[k];
    repeat (6) cycle();
    check("t1_fifo_left", fifoQ.size(), 2);
    grant(typ, pres, bs, dat);
    check("t1_type", typ, 8'h02);
    check("t1_present", pres, 4'b1111);
    check("t1_blockstart", bs, 4'b0001);
    check("t1_data", dat, expData);
    repeat (4) cycle();
    check("t1_fifo_drained", fifoQ.size(), 0);
    check("t1_present_after", samplePresent, 4'b0011);

    // ACR beats a full buffer, and the ACR count keeps its remainder.
    doReset();
    samplesPerRegenPacket = 8'd4;
    sendPacket(1, typ, bs);
    check("t2_first_audio", typ, 8'h02);
    pushWords(4);
    repeat (6) cycle();
    grant(typ, pres, bs, dat);
    check("t2_acr", typ, 8'h01);
    check("t2_acr_buffer_full", pres, 4'b1111);
    grant(typ, pres, bs, dat);
    check("t2_audio_after_acr", typ, 8'h02);
    sendPacket(3, typ, bs);
    check("t2_acr_remainder", typ, 8'h01);

    // InfoFrame order after one vSync edge.
    doReset();
    samplesPerRegenPacket = 8'd0;
    vSyncPulse();
    grant(typ, pres, bs, dat); check("t3_avi", typ, 8'h82);
    grant(typ, pres, bs, dat); check("t3_spd", typ, 8'h83);
    grant(typ, pres, bs, dat); check("t3_audio_if", typ, 8'h84);
    grant(typ, pres, bs, dat); check("t3_null", typ, 8'h00);

    // Second vSync edge with SPD still pending.
    doReset();
    vSyncPulse();
    grant(typ, pres, bs, dat); check("t4_avi", typ, 8'h82);
    missCount = 0;
    vSync = 1'b1;
    cycle();
    if (infoframeMissed) missCount++;
    vSync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (infoframeMissed) missCount++;
    end
    check("t4_missed_once", missCount, 1);
    grant(typ, pres, bs, dat); check("t4_spd", typ, 8'h83);
    grant(typ, pres, bs, dat); check("t4_audio_if", typ, 8'h84);
    grant(typ, pres, bs, dat); check("t4_no_avi_resend", typ, 8'h00);

    // Drive the IEC index to 190, then a 3-sample packet across the block boundary.
    doReset();
    for (int i = 0; i < 47; i++) sendPacket(4, typ, bs);
    sendPacket(2, typ, bs);
    sendPacket(3, typ, bs);
    check("t5_type", typ, 8'h02);
    check("t5_blockstart", bs, 4'b0100);
    for (int i = 0; i < 47; i++) sendPacket(4, typ, bs);
    sendPacket(4, typ, bs);
    check("t5_index_after_wrap", bs, 4'b1000);

    // Asynchronous reset in the middle of a grant.
    doReset();
    pushWords(2);
    repeat (6) cycle();
    slotRequest = 1'b1;
    cycle();
    check("t6_granted", packetValid, 1'b1);
    asyncResetN = 1'b0;
    #1;
    check("t6_valid_drop", packetValid, 1'b0);
    check("t6_type_drop", packetType, 8'h00);
    cycle();
    cycle();
    asyncResetN = 1'b1;
    cycle();
    check("t6_buffer_empty", samplePresent, 4'b0000);
    grant(typ, pres, bs, dat);
    check("t6_null_after", typ, 8'h00);

    // Random traffic against the model.
    doReset();
    samplesPerRegenPacket = 8'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0 && fifoQ.size() < 16) fifoQ.push_back($urandom());
      slotRequest = mGranted ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 4) == 0);
      packetDone  = mGranted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 20) == 0);
      if ($urandom_range(0, 29) == 0) vSync = ~vSync;
      if (c >= 1200 && c % 200 == 0) samplesPerRegenPacket = 8'($urandom_range(0, 6));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
